// File: rtl/seq_frame_pkg.sv
// Shared types and constants for the 1101-start-pattern serial link.
// Used by both the transmitter and the receiver side.
package seq_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_PAYLOAD,
    S_WAIT_ACK,
    S_GAP
  } state_e;

  localparam logic [3:0] PREAMBLE     = 4'b1101;
  localparam int         PREAMBLE_LEN = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_frame_tx_piso_shift.sv
// Parallel-load, MSB-first shift register feeding the serial line.
// Load has priority over shift.
module piso_shift #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         msb
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = d;
    end else if (shift) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: 1101 preamble, MSB-first payload,
// bounded acknowledge wait and a zero guard gap between frames.
module seq_frame_tx
  import seq_frame_pkg::*;
#(
  parameter int PAYLOAD_W   = 4,
  parameter int GAP         = 2,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 in_ready,
  input  logic                 ack,
  output logic                 tx_data,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  localparam int CNT_MAX =
    max2(max2(PREAMBLE_LEN, PAYLOAD_W), max2(ACK_TIMEOUT, GAP));
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
  logic             load;
  logic             shift;
  logic             sr_msb;
  logic [1:0]       pre_idx;

  piso_shift #(
    .W(PAYLOAD_W)
  ) u_piso (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load),
    .shift  (shift),
    .d      (in_data),
    .msb    (sr_msb)
  );

  // tx_d is the bit the line shows during the next cycle
  assign pre_idx = 2'(PREAMBLE_LEN - 2) - cnt_q[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = 1'b0;
    done_d  = 1'b0;
    to_d    = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = S_PRE;
          cnt_d   = '0;
          tx_d    = PREAMBLE[PREAMBLE_LEN-1];
        end
      end
      S_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = S_PAYLOAD;
          cnt_d   = '0;
          tx_d    = sr_msb;
          shift   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          tx_d  = PREAMBLE[pre_idx];
        end
      end
      S_PAYLOAD: begin
        if (cnt_q == PAY_LAST) begin
          state_d = S_WAIT_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          tx_d  = sr_msb;
          shift = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (ack) begin
          state_d = S_GAP;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (cnt_q == ACK_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
          done_d  = 1'b1;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tx_q    <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign tx_data     = tx_q;
  assign done        = done_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: frame timing model plus a 1101 receiver
// model on the serial line, directed and random frames.
module tb_seq_frame_tx;

  localparam int W = 4;
  localparam int T = 8;
  localparam int G = 2;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         ack;
  logic         tx_data;
  logic         busy;
  logic         done;
  logic         timeout_err;

  int vecs;
  int errs;

  seq_frame_tx #(
    .PAYLOAD_W  (W),
    .GAP        (G),
    .ACK_TIMEOUT(T)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ack        (ack),
    .tx_data    (tx_data),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, "_tx"}, 32'(tx_data), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_to"}, 32'(timeout_err), 32'(0));
    chk({tag, "_rdy"}, 32'(in_ready), 32'(1));
  endtask

  // Called at the falling edge of an IDLE cycle; handshakes there.
  // c >= T means the far end never acknowledges in WAIT_ACK.
  task automatic run_frame(input logic [W-1:0] p,
                           input int c,
                           input bit junk,
                           input int abort_t);
    logic [3:0]   pre;
    logic [3:0]   hist;
    logic [W-1:0] rx;
    logic         exp_tx;
    int           skip;
    int           starts;
    int           w0;
    int           done_t;
    int           end_t;
    pre    = 4'b1101;
    w0     = 5 + W;
    done_t = (c < T) ? w0 + c + 1 : w0 + T;
    end_t  = done_t + G;
    hist   = '0;
    rx     = '0;
    skip   = 0;
    starts = 0;
    in_valid = 1'b1;
    in_data  = p;
    ack      = 1'b0;
    for (int t = 1; t <= end_t; t++) begin
      @(negedge clk);
      if (t <= 4)          exp_tx = pre[4-t];
      else if (t <= 4 + W) exp_tx = p[W+4-t];
      else                 exp_tx = 1'b0;
      chk("tx", 32'(tx_data), 32'(exp_tx));
      chk("busy", 32'(busy), 32'(t < end_t));
      chk("in_ready", 32'(in_ready), 32'(t == end_t));
      chk("done", 32'(done), 32'(t == done_t));
      chk("timeout_err", 32'(timeout_err),
          32'((t == done_t) && (c >= T)));
      if (skip > 0) begin
        rx = {rx[W-2:0], tx_data};
        skip--;
        if (skip == 0) chk("rx_payload", 32'(rx), 32'(p));
      end else begin
        hist = {hist[2:0], tx_data};
        if (hist == 4'b1101) begin
          starts++;
          chk("start_pos", 32'(t), 32'(4));
          skip = W;
          hist = '0;
        end
      end
      if (t == abort_t) begin
        #1 reset_n = 1'b0;
        in_valid = 1'b0;
        ack      = 1'b0;
        #1 chk_idle_out("abort");
        repeat (2) begin
          @(negedge clk);
          chk_idle_out("abort_hold");
        end
        reset_n = 1'b1;
        return;
      end
      if (t < w0) begin
        in_valid = junk ? 1'($urandom % 2) : 1'b0;
        in_data  = W'($urandom);
        ack      = junk ? 1'($urandom % 2) : 1'b0;
      end else begin
        in_valid = 1'b0;
        ack      = (t == w0 + c);
      end
    end
    chk("starts", 32'(starts), 32'(1));
    in_valid = 1'b0;
    ack      = 1'b0;
  endtask

  initial begin
    vecs     = 0;
    errs     = 0;
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = '1;
    ack      = 1'b1;
    #2 chk_idle_out("reset");
    repeat (2) begin
      @(negedge clk);
      chk_idle_out("reset_hold");
    end
    in_valid = 1'b0;
    ack      = 1'b0;
    reset_n  = 1'b1;
    @(negedge clk);
    chk_idle_out("post_reset");

    run_frame(4'b1011, 2, 1'b0, 0);
    run_frame(4'b0101, 8, 1'b1, 0);
    run_frame(4'b1011, 9, 1'b0, 0);
    run_frame(4'b1110, 7, 1'b0, 0);
    run_frame(4'b0001, 0, 1'b1, 0);
    run_frame(4'b0110, 2, 1'b0, 6);
    run_frame(4'b1101, 3, 1'b0, 0);

    repeat (12) begin
      run_frame(W'($urandom), int'($urandom_range(0, 9)),
                1'($urandom % 2), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
